// File: rtl/store_drain_buffer.sv
// store_drain_buffer
//
// Purpose: in-order store buffer between the MEM stage and the data memory
// write port. Committed word stores are queued in a circular FIFO and drained
// oldest-first, one per cycle, whenever drain_en allows. Younger loads see
// buffered data via a zero-cycle forward lookup (youngest match wins).
//
// Optional feature (macro STORE_COALESCE_EN): a store to the same word as the
// youngest buffered entry overwrites that entry in place instead of
// allocating, and such a store is accepted even when the buffer is full.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   st_valid/st_ready   store handshake from MEM stage
//   st_addr, st_data    store byte address (bits [1:0] ignored) and data
//   drain_en            permission to write memory this cycle
//   mem_write           memory write strobe (combinational)
//   mem_addr, mem_data  head entry address (word aligned) and data
//   ld_addr             load address for forward lookup (bits [1:0] ignored)
//   ld_hit, ld_data     forward hit and youngest matching data (0 on miss)
//   count, empty, full  occupancy status

module store_drain_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic             drain_en,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned WA_W  = 30;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage: valid bit, word address, data
    logic [DEPTH-1:0] valid_q;
    logic [WA_W-1:0]  wa_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [PTR_W-1:0] young_idx;
    logic [PTR_W-1:0] fwd_idx;
    logic             pop;
    logic             coalesce_match;
    logic             coalesce_wr;
    logic             push_alloc;

    // Address low bits are don't-care for word stores and loads
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    // Occupancy status
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Drain port: head entry goes to memory whenever allowed
    assign mem_write = !empty && drain_en;
    assign pop       = mem_write;
    assign mem_addr  = {wa_q[head_q], 2'b00};
    assign mem_data  = data_q[head_q];

    // Youngest occupied slot, sitting just behind the tail
    assign young_idx = tail_q - PTR_W'(1);

`ifdef STORE_COALESCE_EN
    // Merge into the youngest entry unless that entry is leaving this cycle
    assign coalesce_match = !empty
                          && valid_q[young_idx]
                          && (wa_q[young_idx] == st_addr[31:2])
                          && !(pop && (young_idx == head_q));
    assign st_ready = !full || coalesce_match;
`else
    assign coalesce_match = 1'b0;
    assign st_ready = !full;
`endif

    assign coalesce_wr = st_valid && coalesce_match;
    assign push_alloc  = st_valid && st_ready && !coalesce_match;

    // Forward lookup: walk oldest to youngest so the youngest match wins;
    // the incoming store is not yet in the array and so is never visible
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (valid_q[fwd_idx] && (wa_q[fwd_idx] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end

    // FIFO state update: push at tail, pop at head, occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                wa_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            // tail never equals head here: empty means no pop, full means no alloc
            if (push_alloc) begin
                valid_q[tail_q] <= 1'b1;
                wa_q[tail_q]    <= st_addr[31:2];
                data_q[tail_q]  <= st_data;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (coalesce_wr) begin
                data_q[young_idx] <= st_data;
            end
            case ({push_alloc, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench for store_drain_buffer: a queue-based model of the
// buffer is compared against the DUT every cycle, with directed scenarios
// carrying literal expectations and a randomized soak phase.
module tb_store_drain_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             drain_en;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic [31:0]      ld_addr;
    logic             ld_hit;
    logic [31:0]      ld_data;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;

    store_drain_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data),
        .drain_en(drain_en),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];   // model contents, index 0 = oldest
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pop();
        return (q.size() > 0) && (drain_en == 1'b1);
    endfunction

    function automatic bit m_coal();
`ifdef STORE_COALESCE_EN
        if (q.size() == 0) return 1'b0;
        if (q[q.size()-1].wa != st_addr[31:2]) return 1'b0;
        if (m_pop() && q.size() == 1) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        return (q.size() < int'(DEPTH)) || m_coal();
    endfunction

    // Compare every DUT output against the model for the current inputs
    task automatic compare();
        bit          hit;
        logic [31:0] ldd;
        hit = 1'b0;
        ldd = '0;
        foreach (q[i]) begin
            if (q[i].wa == ld_addr[31:2]) begin
                hit = 1'b1;
                ldd = q[i].d;
            end
        end
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == int'(DEPTH)));
        check("st_ready", 32'(st_ready), 32'(m_ready()));
        check("mem_write", 32'(mem_write), 32'(m_pop()));
        if (q.size() > 0) begin
            check("mem_addr", mem_addr, {q[0].wa, 2'b00});
            check("mem_data", mem_data, q[0].d);
        end
        check("ld_hit", 32'(ld_hit), 32'(hit));
        check("ld_data", ld_data, ldd);
    endtask

    // Advance the model by one edge using the inputs currently applied
    task automatic commit();
        bit   pop;
        bit   coal;
        bit   push;
        ent_t e;
        pop  = m_pop();
        coal = m_coal();
        push = (st_valid == 1'b1) && m_ready();
        if (push && coal) q[q.size()-1].d = st_data;
        if (pop) void'(q.pop_front());
        if (push && !coal) begin
            e.wa = st_addr[31:2];
            e.d  = st_data;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic apply(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic de, input logic [31:0] la);
        @(negedge clk);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        drain_en = de;
        ld_addr  = la;
        #1;
        compare();
    endtask

    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic de, input logic [31:0] la);
        apply(sv, sa, sd, de, la);
        commit();
    endtask

    initial begin
        rst      = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        drain_en = 1'b1;
        ld_addr  = '0;

        // Reset state with drain enabled
        @(negedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_ld_hit", 32'(ld_hit), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("idle_mem_write", 32'(mem_write), 32'd0);
        check("idle_empty", 32'(empty), 32'd1);
        commit();

        // Fill to full, hold off a 5th store, then drain in order
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(32'h100 + 4*i), 32'(32'h11 * (i + 1)), 1'b0, 32'h0);
        apply(1'b1, 32'h500, 32'h55, 1'b0, 32'h0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(st_ready), 32'd0);
        commit();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            check("drain_we", 32'(mem_write), 32'd1);
            check("drain_addr", mem_addr, 32'(32'h100 + 4*i));
            check("drain_data", mem_data, 32'(32'h11 * (i + 1)));
            commit();
        end
        apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_idle_we", 32'(mem_write), 32'd0);
        commit();

        // Same-word stores and forwarding; incoming store not visible
        apply(1'b1, 32'h200, 32'hAA, 1'b0, 32'h200);
        check("fwd_incoming_hidden", 32'(ld_hit), 32'd0);
        commit();
        step(1'b1, 32'h200, 32'hBB, 1'b0, 32'h0);
        apply(1'b0, 32'h0, 32'h0, 1'b0, 32'h202);
`ifdef STORE_COALESCE_EN
        check("fwd_count", 32'(count), 32'd1);
`else
        check("fwd_count", 32'(count), 32'd2);
`endif
        check("fwd_hit", 32'(ld_hit), 32'd1);
        check("fwd_data", ld_data, 32'hBB);
        commit();
        apply(1'b0, 32'h0, 32'h0, 1'b0, 32'h300);
        check("fwd_miss_hit", 32'(ld_hit), 32'd0);
        check("fwd_miss_data", ld_data, 32'd0);
        commit();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

        // Push and pop together at count==1 across pointer wrap;
        // the entry being drained stays forwardable until the edge
        step(1'b1, 32'h400, 32'h1000, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 32'(32'h404 + 4*i), 32'(32'h1001 + i), 1'b1, 32'(32'h400 + 4*i));
            check("pp_count", 32'(count), 32'd1);
            check("pp_addr", mem_addr, 32'(32'h400 + 4*i));
            check("pp_data", mem_data, 32'(32'h1000 + i));
            check("pp_drain_visible", ld_data, 32'(32'h1000 + i));
            commit();
        end
        apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("pp_last_addr", mem_addr, 32'h420);
        commit();

        // Asynchronous reset mid-cycle discards pending stores
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'(32'h600 + 4*i), 32'(32'h77 + i), 1'b0, 32'h0);
        @(negedge clk);
        st_valid = 1'b0;
        drain_en = 1'b1;
        ld_addr  = 32'h600;
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_ready", 32'(st_ready), 32'd1);
        check("arst_mem_write", 32'(mem_write), 32'd0);
        check("arst_ld_hit", 32'(ld_hit), 32'd0);
        check("arst_ld_data", ld_data, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h600);
            check("arst_no_write", 32'(mem_write), 32'd0);
            commit();
        end

`ifdef STORE_COALESCE_EN
        // Coalesce into the youngest entry while full
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(32'h100 + 4*i), 32'(32'h11 * (i + 1)), 1'b0, 32'h0);
        apply(1'b1, 32'h10C, 32'h99, 1'b0, 32'h0);
        check("coal_ready", 32'(st_ready), 32'd1);
        commit();
        apply(1'b1, 32'h110, 32'h5, 1'b0, 32'h0);
        check("coal_count", 32'(count), 32'd4);
        check("coal_block", 32'(st_ready), 32'd0);
        commit();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            check("coal_drain_addr", mem_addr, 32'(32'h100 + 4*i));
            check("coal_drain_data", mem_data, (i == 3) ? 32'h99 : 32'(32'h11 * (i + 1)));
            commit();
        end
`endif

        // Randomized soak against the model
        for (int n = 0; n < 3000; n++) begin
            step(1'b1 && ($urandom_range(0, 9) < 7),
                 32'(32'h800 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3)),
                 $urandom(),
                 1'b1 && ($urandom_range(0, 1) == 1),
                 32'(32'h800 + ($urandom_range(0, 6) << 2) + $urandom_range(0, 3)));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("final_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
